// File: rtl/my_cpu_mc.sv
// Multi-cycle RV32I core: IF/ID/EX/MEM/WB sequencing with a req/ack data bus,
// registered retire trace and cycle/instret counters.
module my_cpu_mc #(
   parameter int unsigned IADDR_W  = 14,
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned CNT_W    = 32
) (
   input  logic               cpu_clk,
   input  logic               cpu_rst,
   output logic [IADDR_W-1:0] inst_addr,
   input  logic [31:0]        inst,
   output logic               Bus_req,
   input  logic               Bus_ack,
   output logic [31:0]        Bus_addr,
   output logic               Bus_we,
   output logic [31:0]        Bus_wdata,
   input  logic [31:0]        Bus_rdata,
   output logic               debug_wb_have_inst,
   output logic [31:0]        debug_wb_pc,
   output logic               debug_wb_ena,
   output logic [4:0]         debug_wb_reg,
   output logic [31:0]        debug_wb_value,
   output logic [CNT_W-1:0]   perf_cycle,
   output logic [CNT_W-1:0]   perf_instret
);
   typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB} state_e;
   typedef enum logic [3:0] {ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
                             ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND} alu_op_e;
   typedef enum logic [1:0] {WB_ALU, WB_MDR, WB_PC4, WB_IMM} wb_sel_e;

   state_e            state_q, state_d;
   logic [31:0]       pc_q, ir_q, a_q, b_q, imm_q, alu_out_q, mdr_q;
   logic              br_q, retire;
   logic [31:0]       rf_q [32];
   logic              have_q, wb_ena_q;
   logic [31:0]       wb_pc_q, wb_value_q;
   logic [4:0]        wb_reg_q;
   logic [CNT_W-1:0]  cycle_q, instret_q;

   logic [6:0]  opcode, funct7;
   logic [2:0]  funct3;
   logic [4:0]  rd, rs1, rs2;
   logic        dec_valid, is_load, is_store, is_branch, is_jal, is_jalr;
   logic        reg_wen, use_imm, use_pc, rf_we, alu_bool;
   alu_op_e     alu_op;
   wb_sel_e     wb_sel;
   logic [31:0] imm, alu_a, alu_b, alu_y, pc_plus4, npc, wb_data, rs1_data, rs2_data;

   assign opcode = ir_q[6:0];
   assign rd     = ir_q[11:7];
   assign funct3 = ir_q[14:12];
   assign rs1    = ir_q[19:15];
   assign rs2    = ir_q[24:20];
   assign funct7 = ir_q[31:25];

   function automatic alu_op_e alu_op_f(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  return alt ? ALU_SUB : ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return alt ? ALU_SRA : ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

   // Decode from the registered IR; anything not recognised stays all-zero (a NOP).
   always_comb begin
      dec_valid = 1'b0; is_load = 1'b0; is_store = 1'b0; is_branch = 1'b0;
      is_jal = 1'b0; is_jalr = 1'b0; reg_wen = 1'b0; use_imm = 1'b0; use_pc = 1'b0;
      wb_sel = WB_ALU; alu_op = ALU_ADD;
      imm = {{20{ir_q[31]}}, ir_q[31:20]};
      case (opcode)
         7'b0110111: begin dec_valid = 1'b1; reg_wen = 1'b1; wb_sel = WB_IMM; imm = {ir_q[31:12], 12'b0}; end
         7'b0010111: begin dec_valid = 1'b1; reg_wen = 1'b1; use_pc = 1'b1; use_imm = 1'b1; imm = {ir_q[31:12], 12'b0}; end
         7'b1101111: begin
            dec_valid = 1'b1; is_jal = 1'b1; reg_wen = 1'b1; wb_sel = WB_PC4;
            imm = {{12{ir_q[31]}}, ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
         end
         7'b1100111: if (funct3 == 3'b000) begin
            dec_valid = 1'b1; is_jalr = 1'b1; reg_wen = 1'b1; wb_sel = WB_PC4; use_imm = 1'b1;
         end
         7'b1100011: begin
            imm = {{20{ir_q[31]}}, ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
            if (funct3[2:1] != 2'b01) begin dec_valid = 1'b1; is_branch = 1'b1; end
         end
         7'b0000011: if (funct3 == 3'b010) begin
            dec_valid = 1'b1; is_load = 1'b1; reg_wen = 1'b1; wb_sel = WB_MDR; use_imm = 1'b1;
         end
         7'b0100011: begin
            imm = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
            if (funct3 == 3'b010) begin dec_valid = 1'b1; is_store = 1'b1; use_imm = 1'b1; end
         end
         7'b0010011: begin
            use_imm = 1'b1;
            alu_op  = alu_op_f(funct3, (funct3 == 3'b101) && ir_q[30]);
            if (funct3 == 3'b001)      dec_valid = (funct7 == 7'b0000000);
            else if (funct3 == 3'b101) dec_valid = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
            else                       dec_valid = 1'b1;
            reg_wen = dec_valid;
         end
         7'b0110011: begin
            alu_op    = alu_op_f(funct3, ir_q[30]);
            dec_valid = (funct7 == 7'b0000000) ||
                        ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
            reg_wen   = dec_valid;
         end
         default: ;
      endcase
   end

   assign rs1_data = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
   assign rs2_data = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];
   assign alu_a    = use_pc  ? pc_q  : a_q;
   assign alu_b    = use_imm ? imm_q : b_q;

   always_comb begin
      alu_y = 32'd0;
      case (alu_op)
         ALU_ADD:  alu_y = alu_a + alu_b;
         ALU_SUB:  alu_y = alu_a - alu_b;
         ALU_SLL:  alu_y = alu_a << alu_b[4:0];
         ALU_SLT:  alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
         ALU_SLTU: alu_y = {31'd0, alu_a < alu_b};
         ALU_XOR:  alu_y = alu_a ^ alu_b;
         ALU_SRL:  alu_y = alu_a >> alu_b[4:0];
         ALU_SRA:  alu_y = $unsigned($signed(alu_a) >>> alu_b[4:0]);
         ALU_OR:   alu_y = alu_a | alu_b;
         ALU_AND:  alu_y = alu_a & alu_b;
         default:  alu_y = 32'd0;
      endcase
   end

   always_comb begin
      alu_bool = 1'b0;
      if (is_branch) begin
         case (funct3)
            3'b000:  alu_bool = (a_q == b_q);
            3'b001:  alu_bool = (a_q != b_q);
            3'b100:  alu_bool = $signed(a_q) <  $signed(b_q);
            3'b101:  alu_bool = $signed(a_q) >= $signed(b_q);
            3'b110:  alu_bool = a_q <  b_q;
            3'b111:  alu_bool = a_q >= b_q;
            default: alu_bool = 1'b0;
         endcase
      end
   end

   assign pc_plus4 = pc_q + 32'd4;

   always_comb begin
      npc = pc_plus4;
      if (is_jal || (is_branch && br_q)) npc = pc_q + imm_q;
      else if (is_jalr)                  npc = {alu_out_q[31:1], 1'b0};
   end

   always_comb begin
      case (wb_sel)
         WB_MDR:  wb_data = mdr_q;
         WB_PC4:  wb_data = pc_plus4;
         WB_IMM:  wb_data = imm_q;
         default: wb_data = alu_out_q;
      endcase
   end

   assign rf_we = (state_q == S_WB) && reg_wen && (rd != 5'd0);

   // Stores retire straight out of S_MEM on ack; everything else retires from S_WB.
   always_comb begin
      state_d = state_q;
      retire  = 1'b0;
      case (state_q)
         S_IF:  state_d = S_ID;
         S_ID:  state_d = S_EX;
         S_EX:  state_d = (is_load || is_store) ? S_MEM : S_WB;
         S_MEM: if (Bus_ack) begin
            if (is_store) begin state_d = S_IF; retire = 1'b1; end
            else          state_d = S_WB;
         end
         S_WB:  begin state_d = S_IF; retire = 1'b1; end
         default: state_d = S_IF;
      endcase
   end

   always_ff @(posedge cpu_clk) begin
      if (cpu_rst) begin
         state_q <= S_IF;   pc_q <= RESET_PC;  ir_q <= 32'd0;
         a_q <= 32'd0;      b_q <= 32'd0;      imm_q <= 32'd0;
         alu_out_q <= 32'd0; mdr_q <= 32'd0;   br_q <= 1'b0;
         have_q <= 1'b0;    wb_ena_q <= 1'b0;  wb_pc_q <= 32'd0;
         wb_reg_q <= 5'd0;  wb_value_q <= 32'd0;
         cycle_q <= '0;     instret_q <= '0;
      end else begin
         state_q <= state_d;
         cycle_q <= cycle_q + CNT_W'(1);
         have_q  <= retire;
         case (state_q)
            S_IF:  ir_q <= inst;
            S_ID:  begin a_q <= rs1_data; b_q <= rs2_data; imm_q <= imm; end
            S_EX:  begin alu_out_q <= alu_y; br_q <= alu_bool; end
            S_MEM: if (Bus_ack && is_load) mdr_q <= Bus_rdata;
            default: ;
         endcase
         if (retire) begin
            pc_q       <= npc;
            instret_q  <= instret_q + CNT_W'(1);
            wb_pc_q    <= pc_q;
            wb_ena_q   <= rf_we;
            wb_reg_q   <= rf_we ? rd : 5'd0;
            wb_value_q <= rf_we ? wb_data : 32'd0;
         end
      end
   end

   always_ff @(posedge cpu_clk) begin
      if (rf_we && !cpu_rst) rf_q[rd] <= wb_data;
   end

   assign inst_addr          = pc_q[IADDR_W+1:2];
   assign Bus_req            = (state_q == S_MEM);
   assign Bus_we             = Bus_req && is_store;
   assign Bus_addr           = alu_out_q;
   assign Bus_wdata          = b_q;
   assign debug_wb_have_inst = have_q;
   assign debug_wb_pc        = wb_pc_q;
   assign debug_wb_ena       = wb_ena_q;
   assign debug_wb_reg       = wb_reg_q;
   assign debug_wb_value     = wb_value_q;
   assign perf_cycle         = cycle_q;
   assign perf_instret       = instret_q;
endmodule

// File: tb/tb_my_cpu_mc.sv
// Directed bench for my_cpu_mc: small IROM program, req/ack bus responder and
// an expected-retire queue checked against the trace port.
module tb_my_cpu_mc;
  localparam int W = 78;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst;
  logic [13:0] inst_addr;
  logic [31:0] inst;
  logic        Bus_req, Bus_ack, Bus_we;
  logic [31:0] Bus_addr, Bus_wdata, Bus_rdata;
  logic        debug_wb_have_inst, debug_wb_ena;
  logic [31:0] debug_wb_pc, debug_wb_value;
  logic [4:0]  debug_wb_reg;
  logic [31:0] perf_cycle, perf_instret;

  logic [31:0] irom [128];
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int n_ret = 0;
  int ack_delay = 0;
  int wait_cnt = 0;
  bit stray_ack = 1'b0;
  logic [31:0] rdata_val = 32'd0;
  int req_cnt = 0;
  logic [31:0] cap_addr, cap_wdata;
  logic cap_we;

  my_cpu_mc dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .inst_addr(inst_addr), .inst(inst),
    .Bus_req(Bus_req), .Bus_ack(Bus_ack), .Bus_addr(Bus_addr), .Bus_we(Bus_we),
    .Bus_wdata(Bus_wdata), .Bus_rdata(Bus_rdata),
    .debug_wb_have_inst(debug_wb_have_inst), .debug_wb_pc(debug_wb_pc),
    .debug_wb_ena(debug_wb_ena), .debug_wb_reg(debug_wb_reg),
    .debug_wb_value(debug_wb_value), .perf_cycle(perf_cycle), .perf_instret(perf_instret)
  );

  // clock / irom
  always #5 cpu_clk = ~cpu_clk;
  assign inst = irom[inst_addr[6:0]];

  // bus responder: acks after ack_delay waiting cycles, runs 2 time units after the edge
  initial begin
    Bus_ack = 1'b0;
    Bus_rdata = 32'd0;
    forever begin
      @(posedge cpu_clk);
      #2;
      if (stray_ack) Bus_ack = 1'b1;
      else if (Bus_req && wait_cnt >= ack_delay) begin
        Bus_ack = 1'b1;
        Bus_rdata = rdata_val;
      end else begin
        Bus_ack = 1'b0;
        if (Bus_req) wait_cnt++;
        else wait_cnt = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge cpu_clk);
    #1;
    if (Bus_req) begin
      req_cnt++;
      cap_addr = Bus_addr;
      cap_we = Bus_we;
      cap_wdata = Bus_wdata;
    end
  endtask

  task automatic push_exp(input logic [31:0] pc, input int lat, input logic ena,
                          input logic [4:0] rd, input logic [31:0] val);
    exp_q.push_back({pc, 8'(lat), ena, rd, val});
  endtask

  // waits (bounded) for the next retire pulse, then compares against the queue head
  task automatic step(input string tag, input int already);
    logic [W-1:0] e;
    int n;
    check({tag, "_expq"}, 32'(exp_q.size() > 0), 32'd1);
    e = exp_q.pop_front();
    req_cnt = 0;
    n = already;
    do begin
      tick();
      n++;
    end while (!debug_wb_have_inst && n < 40);
    n_ret++;
    check({tag, "_lat"}, 32'(n), {24'd0, e[45:38]});
    check({tag, "_pc"}, debug_wb_pc, e[77:46]);
    check({tag, "_ena"}, {31'd0, debug_wb_ena}, {31'd0, e[37]});
    check({tag, "_instret"}, perf_instret, 32'(n_ret));
    if (e[37]) begin
      check({tag, "_reg"}, {27'd0, debug_wb_reg}, {27'd0, e[36:32]});
      check({tag, "_val"}, debug_wb_value, e[31:0]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 128; i++) irom[i] = 32'h0000_0013;
    irom[0]  = 32'h0050_0093; // addi x1,x0,5
    irom[1]  = 32'h0000_A103; // lw   x2,0(x1)
    irom[2]  = 32'h0010_2423; // sw   x1,8(x0)
    irom[3]  = 32'h0070_0013; // addi x0,x0,7
    irom[4]  = 32'hFFFF_FFFF; // undecodable
    irom[5]  = 32'h1234_52B7; // lui  x5,0x12345
    irom[6]  = 32'hFFF0_0313; // addi x6,x0,-1
    irom[7]  = 32'h0060_83B3; // add  x7,x1,x6
    irom[8]  = 32'hFE10_8CE3; // beq  x1,x1,-8
    irom[9]  = 32'h1000_0093; // addi x1,x0,0x100
    irom[10] = 32'h0030_81E7; // jalr x3,3(x1)
    irom[64] = 32'h0000_2483; // lw   x9,0(x0) at 0x102

    push_exp(32'h00, 4, 1'b1, 5'd1, 32'd5);
    push_exp(32'h04, 8, 1'b1, 5'd2, 32'hDEAD_BEEF);
    push_exp(32'h08, 4, 1'b0, 5'd0, 32'd0);
    push_exp(32'h0C, 4, 1'b0, 5'd0, 32'd0);
    push_exp(32'h10, 4, 1'b0, 5'd0, 32'd0);
    push_exp(32'h14, 4, 1'b1, 5'd5, 32'h1234_5000);
    push_exp(32'h18, 4, 1'b1, 5'd6, 32'hFFFF_FFFF);
    push_exp(32'h1C, 4, 1'b1, 5'd7, 32'd4);
    push_exp(32'h20, 4, 1'b0, 5'd0, 32'd0);
    push_exp(32'h18, 4, 1'b1, 5'd6, 32'hFFFF_FFFF);
    push_exp(32'h1C, 4, 1'b1, 5'd7, 32'd4);
    push_exp(32'h20, 4, 1'b0, 5'd0, 32'd0);
    push_exp(32'h24, 4, 1'b1, 5'd1, 32'h100);
    push_exp(32'h28, 4, 1'b1, 5'd3, 32'h2C);

    // reset state
    cpu_rst = 1'b1;
    repeat (3) tick();
    check("rst_inst_addr", {18'd0, inst_addr}, 32'd0);
    check("rst_bus_req", {31'd0, Bus_req}, 32'd0);
    check("rst_bus_we", {31'd0, Bus_we}, 32'd0);
    check("rst_have", {31'd0, debug_wb_have_inst}, 32'd0);
    check("rst_wb_value", debug_wb_value, 32'd0);
    check("rst_cycle", perf_cycle, 32'd0);
    check("rst_instret", perf_instret, 32'd0);
    cpu_rst = 1'b0;

    step("addi_x1", 0);
    check("addi_cycle", perf_cycle, 32'd4);
    ack_delay = 3;
    rdata_val = 32'hDEAD_BEEF;
    step("lw_x2", 0);
    check("lw_req_cycles", 32'(req_cnt), 32'd4);
    check("lw_addr", cap_addr, 32'd5);
    check("lw_we", {31'd0, cap_we}, 32'd0);
    ack_delay = 0;
    step("sw", 0);
    check("sw_req_cycles", 32'(req_cnt), 32'd1);
    check("sw_we", {31'd0, cap_we}, 32'd1);
    check("sw_addr", cap_addr, 32'd8);
    check("sw_wdata", cap_wdata, 32'd5);
    check("sw_next_fetch", {18'd0, inst_addr}, 32'd3);
    tick();
    check("hold_have", {31'd0, debug_wb_have_inst}, 32'd0);
    check("hold_pc", debug_wb_pc, 32'h08);
    step("addi_x0", 1);
    step("undef", 0);
    check("undef_no_bus", 32'(req_cnt), 32'd0);
    step("lui", 0);
    step("addi_x6", 0);
    step("add_x7", 0);
    step("beq", 0);
    check("beq_target", {18'd0, inst_addr}, 32'd6);
    irom[8] = 32'hFE10_9CE3; // bne x1,x1,-8
    step("addi_x6b", 0);
    step("add_x7b", 0);
    step("bne", 0);
    check("bne_target", {18'd0, inst_addr}, 32'd9);
    step("addi_x1b", 0);
    step("jalr", 0);
    check("jalr_target", {18'd0, inst_addr}, 32'h40);

    // reset in the middle of a stalled load
    ack_delay = 100;
    n = 0;
    while (!Bus_req && n < 20) begin
      tick();
      n++;
    end
    check("mem_req_seen", {31'd0, Bus_req}, 32'd1);
    tick();
    check("mem_req_held", {31'd0, Bus_req}, 32'd1);
    cpu_rst = 1'b1;
    tick();
    check("abort_bus_req", {31'd0, Bus_req}, 32'd0);
    check("abort_pc", {18'd0, inst_addr}, 32'd0);
    check("abort_cycle", perf_cycle, 32'd0);
    check("abort_instret", perf_instret, 32'd0);
    check("abort_have", {31'd0, debug_wb_have_inst}, 32'd0);
    cpu_rst = 1'b0;
    ack_delay = 0;
    stray_ack = 1'b1;
    tick();
    stray_ack = 1'b0;
    n_ret = 0;
    push_exp(32'h00, 4, 1'b1, 5'd1, 32'd5);
    step("post_rst_addi", 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
